// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe controller, display and status logic.
package ttt_pkg;

  // Cell contents as stored in the board vector
  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_P1    = 2'd1;
  localparam logic [1:0] CELL_P2    = 2'd2;

  // Controller state encodings
  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_WIN   = 2'd2;
  localparam logic [1:0] ST_DRAW  = 2'd3;

  localparam int N_LINES = 8;

  // Cell triples of every line; entry order matches the win_lines bit order
  localparam logic [3:0] LINE_TBL [N_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},   // row 0
    '{4'd3, 4'd4, 4'd5},   // row 1
    '{4'd6, 4'd7, 4'd8},   // row 2
    '{4'd0, 4'd3, 4'd6},   // col 0
    '{4'd1, 4'd4, 4'd7},   // col 1
    '{4'd2, 4'd5, 4'd8},   // col 2
    '{4'd0, 4'd4, 4'd8},   // diag 0-4-8
    '{4'd2, 4'd4, 4'd6}    // diag 2-4-6
  };

  // Contents of cell k (0..8) of an 18-bit board vector
  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] k);
    return b[{k, 1'b0} +: 2];
  endfunction

  // The other player (1 <-> 2)
  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == CELL_P1) ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational line detector: flags every line fully owned by one player.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  player,
  output logic [7:0]  lines
);

  // Each bit set when all three cells of that line hold the player's mark
  always_comb begin
    lines = '0;
    for (int i = 0; i < N_LINES; i++) begin
      lines[i] = (cell_of(board, LINE_TBL[i][0]) == player) &&
                 (cell_of(board, LINE_TBL[i][1]) == player) &&
                 (cell_of(board, LINE_TBL[i][2]) == player);
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: accepts keypad moves, maintains the board,
// and detects win/draw for the display driver and status indicators.
//
// state | meaning
// PLAY  | waiting for a legal cell press from the player in turn
// CHECK | one cycle evaluating the just-placed mark for win/draw
// WIN   | a player completed a line; play frozen until new_game
// DRAW  | board full with no line; play frozen until new_game
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'd1,
  parameter bit         ALT_START    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        new_game,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic [3:0]  move_cnt,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [7:0]  win_lines,
  output logic        err
);

  logic [1:0]  state_q,     state_d;
  logic [17:0] board_q,     board_d;
  logic [1:0]  turn_q,      turn_d;
  logic [3:0]  move_cnt_q,  move_cnt_d;
  logic        game_over_q, game_over_d;
  logic [1:0]  winner_q,    winner_d;
  logic [7:0]  win_lines_q, win_lines_d;
  logic        err_q,       err_d;
  logic [1:0]  start_q,     start_d;
  logic        key_q;
  logic        new_game_q;

  logic        press;
  logic        key_is_cell;
  logic [3:0]  cell_idx;
  logic [7:0]  lines_done;

  ttt_line_check u_line_check (
    .board  (board_q),
    .player (turn_q),
    .lines  (lines_done)
  );

  assign press       = key_valid & ~key_q;
  assign key_is_cell = (key_code != 4'd0) && (key_code <= 4'd9);
  assign cell_idx    = key_code - 4'd1;

  // Next-state logic: new_game overrides everything, otherwise run the FSM
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    turn_d      = turn_q;
    move_cnt_d  = move_cnt_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    win_lines_d = win_lines_q;
    err_d       = 1'b0;
    start_d     = start_q;

    // Starting player only flips on the new_game rising edge, so a held
    // request keeps the board cleared without toggling repeatedly
    if (ALT_START && new_game && !new_game_q) begin
      start_d = other_player(start_q);
    end

    if (new_game) begin
      state_d     = ST_PLAY;
      board_d     = '0;
      turn_d      = start_d;
      move_cnt_d  = 4'd0;
      game_over_d = 1'b0;
      winner_d    = CELL_EMPTY;
      win_lines_d = '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (press && key_is_cell) begin
            if (cell_of(board_q, cell_idx) == CELL_EMPTY) begin
              board_d[{cell_idx, 1'b0} +: 2] = turn_q;
              move_cnt_d = move_cnt_q + 4'd1;
              state_d    = ST_CHECK;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          // Win is tested before the full-board draw so a 9th-move win counts
          if (|lines_done) begin
            state_d     = ST_WIN;
            winner_d    = turn_q;
            win_lines_d = lines_done;
            game_over_d = 1'b1;
          end else if (move_cnt_q == 4'd9) begin
            state_d     = ST_DRAW;
            winner_d    = CELL_EMPTY;
            game_over_d = 1'b1;
          end else begin
            turn_d  = other_player(turn_q);
            state_d = ST_PLAY;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers; key and new_game history sampled every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PLAY;
      board_q     <= '0;
      turn_q      <= FIRST_PLAYER;
      move_cnt_q  <= 4'd0;
      game_over_q <= 1'b0;
      winner_q    <= CELL_EMPTY;
      win_lines_q <= '0;
      err_q       <= 1'b0;
      start_q     <= FIRST_PLAYER;
      key_q       <= 1'b0;
      new_game_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      turn_q      <= turn_d;
      move_cnt_q  <= move_cnt_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      win_lines_q <= win_lines_d;
      err_q       <= err_d;
      start_q     <= start_d;
      key_q       <= key_valid;
      new_game_q  <= new_game;
    end
  end

  assign board     = board_q;
  assign turn      = turn_q;
  assign move_cnt  = move_cnt_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign win_lines = win_lines_q;
  assign err       = err_q;

endmodule
